// File: rtl/fsic_coreclk_tx_framer.sv
// Coreclk-side TX framer for the io_serdes serializer.
// Drives the coreclk phase toggle, sends a training word until the far end
// reports phase lock, then streams input words through a 2-entry skid buffer
// into a registered transmit word. Idle words fill any gaps.
module fsic_coreclk_tx_framer #(
  parameter int                     pDATA_WIDTH    = 32,
  parameter int                     pTRAIN_CYCLES  = 16,
  parameter logic [pDATA_WIDTH-1:0] pTRAIN_PATTERN = 32'hA5A5_5A5A,
  parameter logic [pDATA_WIDTH-1:0] pIDLE_WORD     = 32'h0000_0000
) (
  input  logic                   coreclk,
  input  logic                   axis_rst_n,
  input  logic                   serdes_en,
  input  logic                   phase_locked_io,
  input  logic                   rx_ready,
  input  logic [pDATA_WIDTH-1:0] in_tdata,
  input  logic                   in_tvalid,
  output logic                   in_tready,
  output logic                   core_toggle,
  output logic [pDATA_WIDTH-1:0] tx_word,
  output logic                   tx_word_valid,
  output logic [1:0]             link_state
);

  localparam int             CW   = $clog2(pTRAIN_CYCLES + 1);
  localparam logic [CW-1:0]  CMAX = CW'(pTRAIN_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TRAIN = 2'd1,
    S_DATA  = 2'd2
  } state_t;

  state_t                         state, nxt;
  logic [CW-1:0]                  cnt;
  logic                           sync1, locked_s;
  logic [1:0][pDATA_WIDTH-1:0]    skid;
  logic [1:0]                     occ, occ_nxt;
  logic                           push, pop;
  logic [pDATA_WIDTH-1:0]         head;

  assign link_state = state;

  // Phase reference: free-running divide-by-two of coreclk
  always_ff @(posedge coreclk or negedge axis_rst_n) begin
    if (!axis_rst_n) core_toggle <= 1'b0;
    else             core_toggle <= ~core_toggle;
  end

  // Two-flop synchronizer for the ioclk-domain lock flag
  always_ff @(posedge coreclk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      sync1    <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync1    <= phase_locked_io;
      locked_s <= sync1;
    end
  end

  // Next link state; dropping serdes_en overrides every other transition
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:  if (serdes_en) nxt = S_TRAIN;
      S_TRAIN: if (cnt == CMAX && locked_s) nxt = S_DATA;
      S_DATA:  if (!locked_s) nxt = S_TRAIN;
      default: nxt = S_IDLE;
    endcase
    if (!serdes_en) nxt = S_IDLE;
  end

  // Skid handshake: an empty buffer lets the incoming word bypass straight
  // to tx_word so a word accepted at cycle N is on the wire at N+1.
  always_comb begin
    push    = in_tvalid & in_tready & (occ != 2'd2);
    pop     = (nxt == S_DATA) & rx_ready & ((occ != 2'd0) | push);
    head    = (occ == 2'd0) ? in_tdata : skid[0];
    occ_nxt = occ + {1'b0, push} - {1'b0, pop};
    if (!serdes_en) occ_nxt = 2'd0;
  end

  // State, training counter and ready flag
  always_ff @(posedge coreclk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      in_tready <= 1'b0;
    end else begin
      state     <= nxt;
      in_tready <= (nxt == S_DATA) && (occ_nxt < 2'd2);
      if (nxt == S_TRAIN && state == S_TRAIN) begin
        if (cnt != CMAX) cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
    end
  end

  // Skid storage in FIFO order; flushed only when the link is disabled
  always_ff @(posedge coreclk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      occ  <= 2'd0;
      skid <= '0;
    end else begin
      occ <= occ_nxt;
      if (serdes_en) begin
        unique case ({push, pop})
          2'b10:   skid[occ[0]] <= in_tdata;
          2'b01:   skid[0]      <= skid[1];
          2'b11:   if (occ == 2'd1) skid[0] <= in_tdata;
          default: ;
        endcase
      end
    end
  end

  // Registered transmit word, aligned with the registered link state
  always_ff @(posedge coreclk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      tx_word       <= pIDLE_WORD;
      tx_word_valid <= 1'b0;
    end else begin
      tx_word       <= pIDLE_WORD;
      tx_word_valid <= 1'b0;
      if (nxt == S_TRAIN) begin
        tx_word <= pTRAIN_PATTERN;
      end else if (pop) begin
        tx_word       <= head;
        tx_word_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fsic_coreclk_tx_framer.sv
// Directed bench for fsic_coreclk_tx_framer with a data scoreboard.
module tb_fsic_coreclk_tx_framer;

  localparam logic [31:0] PAT  = 32'hA5A5_5A5A;
  localparam logic [31:0] IDLW = 32'h0000_0000;

  logic        coreclk, axis_rst_n, serdes_en, phase_locked_io, rx_ready;
  logic [31:0] in_tdata;
  logic        in_tvalid, in_tready, core_toggle, tx_word_valid;
  logic [31:0] tx_word;
  logic [1:0]  link_state;

  int          total = 0;
  int          bad   = 0;
  int          n_out = 0;
  logic        exp_tog;
  logic [31:0] exp_q[$];

  fsic_coreclk_tx_framer dut (
    .coreclk         (coreclk),
    .axis_rst_n      (axis_rst_n),
    .serdes_en       (serdes_en),
    .phase_locked_io (phase_locked_io),
    .rx_ready        (rx_ready),
    .in_tdata        (in_tdata),
    .in_tvalid       (in_tvalid),
    .in_tready       (in_tready),
    .core_toggle     (core_toggle),
    .tx_word         (tx_word),
    .tx_word_valid   (tx_word_valid),
    .link_state      (link_state)
  );

  initial coreclk = 1'b0;
  always #5 coreclk = ~coreclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: capture handshake, advance, then score the outputs
  task automatic tick(output logic acc);
    logic [31:0] d;
    acc = in_tvalid && in_tready;
    d   = in_tdata;
    @(posedge coreclk); #1;
    exp_tog = ~exp_tog;
    if (acc) exp_q.push_back(d);
    chk("toggle", 32'(core_toggle), 32'(exp_tog));
    if (tx_word_valid) begin
      n_out++;
      chk("q_has_entry", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) chk("data", tx_word, exp_q.pop_front());
    end else begin
      chk("fill_word", tx_word, (link_state == 2'd1) ? PAT : IDLW);
    end
  endtask

  task automatic step();
    logic a;
    tick(a);
  endtask

  // Count TRAIN cycles from enable until DATA (bounded)
  task automatic train_len(output int n);
    n = 0;
    for (int k = 0; k < 40 && link_state != 2'd2; k++) begin
      if (link_state == 2'd1) n++;
      step();
    end
  endtask

  // Offer words until `want` are accepted or the budget runs out
  task automatic send_n(input logic [31:0] base, input int want, input int budget, output int got);
    logic a;
    got = 0;
    for (int k = 0; k < budget && got < want; k++) begin
      in_tdata  = base + 32'(got);
      in_tvalid = 1'b1;
      tick(a);
      if (a) got++;
    end
    in_tvalid = 1'b0;
  endtask

  initial begin
    int n, got, i, out0;
    logic a;
    axis_rst_n = 1'b0; serdes_en = 1'b0; phase_locked_io = 1'b1;
    rx_ready = 1'b0; in_tdata = '0; in_tvalid = 1'b0; exp_tog = 1'b0;
    #12;
    chk("rst_ready", 32'(in_tready), 32'd0);
    chk("rst_toggle", 32'(core_toggle), 32'd0);
    chk("rst_word", tx_word, IDLW);
    chk("rst_valid", 32'(tx_word_valid), 32'd0);
    chk("rst_state", 32'(link_state), 32'd0);
    @(posedge coreclk); #1;
    axis_rst_n = 1'b1;

    // 1: lock present from the start
    serdes_en = 1'b1;
    train_len(n);
    chk("t1_train_len", 32'(n >= 16 && n <= 17), 32'd1);
    chk("t1_data", 32'(link_state), 32'd2);
    chk("t1_ready", 32'(in_tready), 32'd1);

    // 2: lock arrives late; two-cycle synchronizer delay
    serdes_en = 1'b0; phase_locked_io = 1'b0;
    step();
    chk("t2_idle", 32'(link_state), 32'd0);
    serdes_en = 1'b1;
    repeat (30) step();
    chk("t2_hold", 32'(link_state), 32'd1);
    phase_locked_io = 1'b1;
    step(); chk("t2_sync1", 32'(link_state), 32'd1);
    step(); chk("t2_sync2", 32'(link_state), 32'd1);
    step(); chk("t2_data", 32'(link_state), 32'd2);

    // 3: back-to-back stream, one-cycle latency
    rx_ready = 1'b1;
    for (int w = 1; w <= 3; w++) begin
      in_tdata = 32'(w); in_tvalid = 1'b1;
      tick(a);
      chk("t3_acc", 32'(a), 32'd1);
      chk("t3_valid", 32'(tx_word_valid), 32'd1);
    end
    in_tvalid = 1'b0;
    step();
    chk("t3_gap_valid", 32'(tx_word_valid), 32'd0);
    chk("t3_drain", 32'(exp_q.size()), 32'd0);

    // 4: backpressure fills the skid, then drains in order
    rx_ready = 1'b0; i = 0; out0 = n_out;
    repeat (4) begin
      in_tdata = 32'h11 + 32'(i); in_tvalid = 1'b1;
      tick(a);
      if (a) i++;
      chk("t4_hold", 32'(tx_word_valid), 32'd0);
    end
    chk("t4_accepted", 32'(i), 32'd2);
    chk("t4_ready", 32'(in_tready), 32'd0);
    rx_ready = 1'b1;
    for (int k = 0; k < 20 && i < 4; k++) begin
      in_tdata = 32'h11 + 32'(i); in_tvalid = 1'b1;
      tick(a);
      if (a) i++;
    end
    in_tvalid = 1'b0;
    chk("t4_all_acc", 32'(i), 32'd4);
    repeat (4) step();
    chk("t4_drain", 32'(exp_q.size()), 32'd0);
    chk("t4_count", 32'(n_out - out0), 32'd4);

    // 5: retrain with two words buffered
    rx_ready = 1'b0;
    send_n(32'h21, 2, 10, got);
    chk("t5_fill", 32'(got), 32'd2);
    chk("t5_full", 32'(in_tready), 32'd0);
    phase_locked_io = 1'b0;
    for (int k = 0; k < 10 && link_state != 2'd1; k++) step();
    chk("t5_train", 32'(link_state), 32'd1);
    rx_ready = 1'b1; n = 0; out0 = n_out;
    repeat (20) begin
      step();
      if (link_state == 2'd1) n++;
    end
    chk("t5_train_len", 32'(n), 32'd20);
    chk("t5_no_out", 32'(n_out - out0), 32'd0);
    phase_locked_io = 1'b1;
    for (int k = 0; k < 25 && link_state != 2'd2; k++) step();
    chk("t5_relock", 32'(link_state), 32'd2);
    repeat (3) step();
    chk("t5_drain", 32'(exp_q.size()), 32'd0);
    chk("t5_count", 32'(n_out - out0), 32'd2);

    // 6: disable with a full skid flushes it
    rx_ready = 1'b0;
    send_n(32'h31, 2, 10, got);
    chk("t6_fill", 32'(got), 32'd2);
    serdes_en = 1'b0;
    step();
    chk("t6_idle", 32'(link_state), 32'd0);
    chk("t6_ready", 32'(in_tready), 32'd0);
    chk("t6_word", tx_word, IDLW);
    chk("t6_valid", 32'(tx_word_valid), 32'd0);
    exp_q.delete();
    rx_ready = 1'b1; serdes_en = 1'b1; out0 = n_out;
    train_len(n);
    chk("t6_train_len", 32'(n >= 16 && n <= 17), 32'd1);
    chk("t6_data", 32'(link_state), 32'd2);
    repeat (5) step();
    chk("t6_flushed", 32'(n_out - out0), 32'd0);
    in_tdata = 32'h41; in_tvalid = 1'b1;
    tick(a);
    in_tvalid = 1'b0;
    chk("t6_acc", 32'(a), 32'd1);
    chk("t6_valid_out", 32'(tx_word_valid), 32'd1);

    // Asynchronous reset mid-operation
    #3 axis_rst_n = 1'b0;
    #1;
    chk("ar_state", 32'(link_state), 32'd0);
    chk("ar_ready", 32'(in_tready), 32'd0);
    chk("ar_word", tx_word, IDLW);
    chk("ar_valid", 32'(tx_word_valid), 32'd0);
    chk("ar_toggle", 32'(core_toggle), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
